// File: rtl/cnn_pkg.sv
// Shared parameters and FSM encodings for the CNN pixel-stream blocks.
package cnn_pkg;

    localparam int unsigned DW   = 32;
    localparam int unsigned CH   = 3;
    localparam int unsigned IN_W = 13;

    typedef enum logic {
        ST_PASS   = 1'b0,
        ST_REPEAT = 1'b1
    } up_state_t;

endpackage

// File: rtl/upsample1_linebuffer.sv
// One-row pixel store: synchronous write, combinational read.
module upsample1_linebuffer #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 13,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/upsample1.sv
// 2x nearest-neighbour upsampler: each input row is emitted twice per pixel,
// then replayed from the line buffer to form the odd output row.
module upsample1 #(
    parameter int unsigned DW   = cnn_pkg::DW,
    parameter int unsigned CH   = cnn_pkg::CH,
    parameter int unsigned IN_W = cnn_pkg::IN_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DW*CH-1:0]    data_in,
    input  logic                data_in_valid,
    output logic                data_in_ready,
    output logic [DW*CH-1:0]    data_out,
    output logic                data_out_valid,
    input  logic                data_out_ready,
    output logic                frame_done
);
    import cnn_pkg::*;

    localparam int unsigned PW    = DW * CH;
    localparam int unsigned OUT_W = 2 * IN_W;
    localparam int unsigned XW    = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int unsigned OXW   = $clog2(OUT_W);
    localparam logic [XW-1:0]  IN_MAX  = XW'(IN_W - 1);
    localparam logic [OXW-1:0] OUT_MAX = OXW'(OUT_W - 1);

    up_state_t        state, state_d;
    logic             phase, phase_d;
    logic [XW-1:0]    in_x, in_x_d, in_y, in_y_d;
    logic [OXW-1:0]   out_x, out_x_d, out_y, out_y_d;
    logic [PW-1:0]    data_out_d;
    logic             data_out_valid_d;
    logic             frame_done_d;

    logic             in_fire, out_fire, last_x, last_y;
    logic [XW-1:0]    lb_rd_addr;
    logic [PW-1:0]    lb_rd_data;

    assign last_x   = (out_x == OUT_MAX);
    assign last_y   = (out_y == OUT_MAX);
    assign out_fire = data_out_valid && data_out_ready;
    assign in_fire  = data_in_valid && data_in_ready;

    // The last pixel of an even row is never overlapped with a new input,
    // since the next input belongs to the row after the replay.
    assign data_in_ready = !rst_n && (state == ST_PASS) &&
                           (!data_out_valid || (phase && data_out_ready && !last_x));

    // Line-buffer read follows the column about to be presented.
    always_comb begin
        out_x_d = out_x;
        if (out_fire) begin
            out_x_d = last_x ? '0 : out_x + OXW'(1);
        end
        lb_rd_addr = XW'(out_x_d >> 1);
    end

    upsample1_linebuffer #(
        .WIDTH (PW),
        .DEPTH (IN_W),
        .AW    (XW)
    ) u_linebuffer (
        .clk     (clk),
        .wr_en   (in_fire),
        .wr_addr (in_x),
        .wr_data (data_in),
        .rd_addr (lb_rd_addr),
        .rd_data (lb_rd_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= ST_PASS;
        end else begin
            state <= state_d;
        end
    end

    // Next state, counters and registered outputs.
    always_comb begin
        state_d          = state;
        phase_d          = phase;
        in_x_d           = in_x;
        in_y_d           = in_y;
        out_y_d          = out_y;
        data_out_d       = data_out;
        data_out_valid_d = data_out_valid;
        frame_done_d     = 1'b0;

        case (state)
            ST_PASS: begin
                if (out_fire) begin
                    phase_d = !phase;
                    if (last_x) begin
                        out_y_d          = out_y + OXW'(1);
                        state_d          = ST_REPEAT;
                        data_out_d       = lb_rd_data;
                        data_out_valid_d = 1'b1;
                    end else if (phase) begin
                        data_out_valid_d = 1'b0;
                    end
                end
                if (in_fire) begin
                    data_out_d       = data_in;
                    data_out_valid_d = 1'b1;
                    in_x_d           = (in_x == IN_MAX) ? '0 : in_x + XW'(1);
                    if (in_x == IN_MAX) begin
                        in_y_d = (in_y == IN_MAX) ? '0 : in_y + XW'(1);
                    end
                end
            end
            ST_REPEAT: begin
                if (out_fire) begin
                    phase_d = !phase;
                    if (last_x) begin
                        data_out_valid_d = 1'b0;
                        state_d          = ST_PASS;
                        if (last_y) begin
                            out_y_d      = '0;
                            in_x_d       = '0;
                            in_y_d       = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            out_y_d = out_y + OXW'(1);
                        end
                    end else if (phase) begin
                        data_out_d = lb_rd_data;
                    end
                end
            end
            default: begin
                state_d = ST_PASS;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            phase          <= 1'b0;
            in_x           <= '0;
            in_y           <= '0;
            out_x          <= '0;
            out_y          <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            phase          <= phase_d;
            in_x           <= in_x_d;
            in_y           <= in_y_d;
            out_x          <= out_x_d;
            out_y          <= out_y_d;
            data_out       <= data_out_d;
            data_out_valid <= data_out_valid_d;
            frame_done     <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_upsample1.sv
// Scoreboard bench for upsample1: a row model queues expected output beats.
module tb_upsample1;

    localparam int DW          = 32;
    localparam int CH          = 3;
    localparam int IN_W        = 13;
    localparam int OUT_W       = 2 * IN_W;
    localparam int PW          = DW * CH;
    localparam int FRAME_BEATS = OUT_W * OUT_W;

    logic          clk;
    logic          rst_n;
    logic [PW-1:0] data_in;
    logic          data_in_valid;
    logic          data_in_ready;
    logic [PW-1:0] data_out;
    logic          data_out_valid;
    logic          data_out_ready;
    logic          frame_done;

    upsample1 #(.DW(DW), .CH(CH), .IN_W(IN_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .frame_done     (frame_done)
    );

    int            total = 0;
    int            bad   = 0;
    logic [PW-1:0] in_q[$];
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] row_buf [IN_W];
    int            mx      = 0;
    int            beats   = 0;
    int            frames  = 0;
    bit            mon_en  = 0;
    bit            stall   = 0;
    int            in_pct  = 100;
    int            out_pct = 100;
    bit            prev_stall = 0;
    logic [PW-1:0] prev_data;
    logic [PW-1:0] exp_v;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit, got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [PW-1:0] rep(input logic [DW-1:0] v);
        return {CH{v}};
    endfunction

    // Each accepted input yields two even-row beats; a completed row yields its replay.
    task automatic model_accept(input logic [PW-1:0] d);
        exp_q.push_back(d);
        exp_q.push_back(d);
        row_buf[mx] = d;
        mx++;
        if (mx == IN_W) begin
            mx = 0;
            for (int i = 0; i < OUT_W; i++) exp_q.push_back(row_buf[i/2]);
        end
    endtask

    task automatic push_frame(input int offset);
        for (int y = 0; y < IN_W; y++)
            for (int x = 0; x < IN_W; x++)
                in_q.push_back(rep(DW'(x + 16*y + offset)));
    endtask

    task automatic drain(input int budget, output bit timed_out);
        int c = 0;
        while ((in_q.size() != 0 || exp_q.size() != 0) && c < budget) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
        timed_out = (c >= budget);
    endtask

    // Input driver: changes just after the rising edge.
    initial begin
        data_in_valid  = 1'b0;
        data_in        = '0;
        data_out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (in_q.size() > 0 && int'($urandom_range(99)) < in_pct) begin
                data_in_valid = 1'b1;
                data_in       = in_q[0];
            end else begin
                data_in_valid = 1'b0;
            end
            data_out_ready = !stall && (int'($urandom_range(99)) < out_pct);
        end
    end

    // Monitor: scoreboard compare, stall stability and frame_done accounting.
    initial begin
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    total++;
                    if (data_out_valid !== 1'b1 || data_out !== prev_data) begin
                        bad++;
                        $display("FAIL hold_stable: got valid=%b data=%h exp valid=1 data=%h",
                                 data_out_valid, data_out, prev_data);
                    end
                end
                prev_stall = data_out_valid && !data_out_ready;
                prev_data  = data_out;
                if (data_in_valid && data_in_ready) model_accept(in_q.pop_front());
                if (data_out_valid && data_out_ready) begin
                    total++;
                    beats++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL scoreboard_extra: got=%h exp=none", data_out);
                    end else begin
                        exp_v = exp_q.pop_front();
                        if (data_out !== exp_v) begin
                            bad++;
                            $display("FAIL scoreboard: beat=%0d got=%h exp=%h", beats, data_out, exp_v);
                        end
                    end
                end
                if (frame_done) begin
                    total++;
                    frames++;
                    if (beats !== FRAME_BEATS) begin
                        bad++;
                        $display("FAIL frame_beats: got=%0d exp=%0d", beats, FRAME_BEATS);
                    end
                    beats = 0;
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (data_out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got=%b exp=0", data_out_valid); end
        total++;
        if (data_in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got=%b exp=0", data_in_ready); end
        total++;
        if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done: got=%b exp=0", frame_done); end
        total++;
        if (data_out !== '0) begin bad++; $display("FAIL reset_data: got=%h exp=0", data_out); end
        @(posedge clk);
        #1 rst_n = 1'b0;
        mon_en = 1;
        @(negedge clk);
        total++;
        if (data_in_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset: got=%b exp=1", data_in_ready); end
    endtask

    task automatic test_full_frame();
        int  n  = 0;
        int  f0 = frames;
        bit  to;
        logic [PW-1:0] e;
        push_frame(0);
        for (int g = 0; g < 5000 && n < FRAME_BEATS; g++) begin
            @(negedge clk);
            if (data_out_valid && data_out_ready) begin
                e = rep(DW'((n % OUT_W) / 2 + 16 * ((n / OUT_W) / 2)));
                total++;
                if (data_out !== e) begin
                    bad++;
                    $display("FAIL full_frame_pixel: x=%0d y=%0d got=%h exp=%h", n % OUT_W, n / OUT_W, data_out, e);
                end
                n++;
            end
        end
        drain(5000, to);
        total++;
        if (to || n != FRAME_BEATS) begin bad++; $display("FAIL full_frame_count: got=%0d exp=%0d", n, FRAME_BEATS); end
        total++;
        if (frames != f0 + 1) begin bad++; $display("FAIL full_frame_done: got=%0d exp=%0d", frames - f0, 1); end
    endtask

    task automatic test_stall();
        int n  = 0;
        int f0 = frames;
        bit to;
        logic [PW-1:0] d0;
        push_frame(3);
        for (int g = 0; g < 500 && n < 6; g++) begin
            @(negedge clk);
            if (data_out_valid && data_out_ready) n++;
        end
        @(posedge clk);
        stall = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) d0 = data_out;
            total++;
            if (data_out_valid !== 1'b1 || data_out !== d0) begin
                bad++;
                $display("FAIL stall_frozen: cyc=%0d got=%h exp=%h", i, data_out, d0);
            end
            total++;
            if (data_in_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_in_ready: cyc=%0d got=%b exp=0", i, data_in_ready);
            end
        end
        @(posedge clk);
        stall = 0;
        drain(5000, to);
        total++;
        if (to || frames != f0 + 1) begin bad++; $display("FAIL stall_frame: got=%0d exp=%0d", frames - f0, 1); end
    endtask

    task automatic test_repeat_block();
        int n  = 0;
        int f0 = frames;
        bit to;
        push_frame(5);
        for (int g = 0; g < 500 && n < OUT_W; g++) begin
            @(negedge clk);
            if (data_out_valid && data_out_ready) n++;
        end
        for (int i = 0; i < OUT_W; i++) begin
            @(negedge clk);
            total++;
            if (data_in_valid !== 1'b1 || data_in_ready !== 1'b0 || data_out_valid !== 1'b1) begin
                bad++;
                $display("FAIL repeat_block: beat=%0d got in_ready=%b out_valid=%b exp in_ready=0 out_valid=1",
                         i, data_in_ready, data_out_valid);
            end
        end
        @(negedge clk);
        total++;
        if (data_in_ready !== 1'b1) begin bad++; $display("FAIL repeat_release: got=%b exp=1", data_in_ready); end
        drain(5000, to);
        total++;
        if (to || frames != f0 + 1) begin bad++; $display("FAIL repeat_frame: got=%0d exp=%0d", frames - f0, 1); end
    endtask

    task automatic test_random_back_to_back();
        int f0 = frames;
        bit to;
        in_pct  = 50;
        out_pct = 50;
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < IN_W * IN_W; i++)
                in_q.push_back({$urandom, $urandom, $urandom});
        drain(30000, to);
        in_pct  = 100;
        out_pct = 100;
        total++;
        if (to) begin bad++; $display("FAIL random_drain: got=timeout exp=drained"); end
        total++;
        if (frames != f0 + 3) begin bad++; $display("FAIL random_frames: got=%0d exp=%0d", frames - f0, 3); end
    endtask

    task automatic test_midframe_reset();
        int n  = 0;
        int f0;
        bit done = 0;
        bit to;
        push_frame(64);
        for (int g = 0; g < 2000 && !done; g++) begin
            @(negedge clk);
            if (data_out_valid && n == 5 * OUT_W + 10) done = 1;
            else if (data_out_valid && data_out_ready) n++;
        end
        total++;
        if (!done || data_out !== rep(DW'(5 + 16 * 2 + 64))) begin
            bad++;
            $display("FAIL pixel_10_5: got=%h exp=%h", data_out, rep(DW'(5 + 16 * 2 + 64)));
        end
        mon_en = 0;
        rst_n  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (data_out_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid: got=%b exp=0", data_out_valid); end
        in_q.delete();
        exp_q.delete();
        mx    = 0;
        beats = 0;
        f0    = frames;
        @(posedge clk);
        #1 rst_n = 1'b0;
        mon_en = 1;
        push_frame(128);
        drain(5000, to);
        total++;
        if (to || frames != f0 + 1) begin bad++; $display("FAIL midreset_frame: got=%0d exp=%0d", frames - f0, 1); end
    endtask

    task automatic test_channels();
        int  f0 = frames;
        bit  seen = 0;
        bit  to;
        logic [PW-1:0] px;
        px = {32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
        for (int i = 0; i < IN_W * IN_W; i++) in_q.push_back(px);
        for (int g = 0; g < 100 && !seen; g++) begin
            @(negedge clk);
            if (data_out_valid && data_out_ready) seen = 1;
        end
        total++;
        if (!seen || data_out[DW-1:0] !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL chan0: got=%h exp=ffffffff", data_out[DW-1:0]);
        end
        total++;
        if (!seen || data_out[2*DW-1:DW] !== 32'h0) begin
            bad++; $display("FAIL chan1: got=%h exp=00000000", data_out[2*DW-1:DW]);
        end
        total++;
        if (!seen || data_out[3*DW-1:2*DW] !== 32'h8000_0000) begin
            bad++; $display("FAIL chan2: got=%h exp=80000000", data_out[3*DW-1:2*DW]);
        end
        drain(5000, to);
        total++;
        if (to || frames != f0 + 1) begin bad++; $display("FAIL chan_frame: got=%0d exp=%0d", frames - f0, 1); end
    endtask

    initial begin
        rst_n = 1'b1;
        test_reset();
        test_full_frame();
        test_stall();
        test_repeat_block();
        test_random_back_to_back();
        test_midframe_reset();
        test_channels();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
